// File: rtl/calc_core_param.sv
// calc_core_param: keypad-driven signed calculator core.
// Multi-digit sign-magnitude operands, chained operators, a valid/ready command
// port, a sequential shift-add multiplier and a double-dabble binary-to-BCD
// converter.
// The core drives DIGITS seven-segment digits straight from a register.
module calc_core_param #(
   parameter int DIGITS         = 8,
   parameter int WIDTH          = 24,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [3:0]          cmd,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   output logic                busy,
   output logic                err,
   output logic [8*DIGITS-1:0] d
);
   localparam int ND = DIGITS - 1;
   localparam int BW = 4 * ND;
   localparam int CW = $clog2(DIGITS);
   localparam int SW = $clog2(WIDTH);
   localparam logic [2*WIDTH-1:0]  MAX_VAL   = (2*WIDTH)'(10**ND - 1);
   localparam logic [SW-1:0]       LAST_STEP = SW'(WIDTH - 1);
   localparam logic [8*DIGITS-1:0] RESET_IMG = {{(8*DIGITS-8){1'b0}}, 8'h3F};
   localparam logic [3:0] CMD_CLR = 4'hD;
   localparam logic [3:0] CMD_EQ  = 4'hE;
   localparam logic [3:0] CMD_BS  = 4'hF;
   localparam logic [1:0] OP_ADD  = 2'd0;
   localparam logic [1:0] OP_SUB  = 2'd1;
   localparam logic [1:0] OP_MUL  = 2'd2;

   typedef enum logic [2:0] {
      ST_OPA, ST_OP, ST_OPB, ST_EXEC, ST_CONV, ST_RESULT, ST_ERR
   } state_t;

   state_t              state_r;
   logic [1:0]          op_r, pend_op_r, op_s;
   logic                chain_r, a_neg_r, busy_r;
   logic [WIDTH-1:0]    a_mag_r, b_mag_r;
   logic [CW-1:0]       cnt_r;
   logic [BW-1:0]       bcd_r;
   logic [SW-1:0]       step_r;
   logic [2*WIDTH-1:0]  prod_r, mcand_r;
   logic [8*DIGITS-1:0] d_r;

   logic                accept_s, is_digit_s, is_oper_s, can_push_s;
   logic [CW-1:0]       cnt_inc_s, cnt_dec_s, first_cnt_s;
   logic [WIDTH-1:0]    ent_mag_s, push_mag_s, pop_mag_s, digit_mag_s;
   logic [BW-1:0]       push_bcd_s, pop_bcd_s, digit_bcd_s, conv_bcd_s;
   logic                b_neg_s, as_neg_s, as_ovf_s, mul_neg_s, mul_ovf_s;
   logic [WIDTH:0]      as_sum_s;
   logic [2*WIDTH-1:0]  prod_next_s;
   logic [WIDTH-1:0]    res_mag_s;
   logic                res_neg_s, res_ovf_s, disp_neg_s, seen_s;
   logic [8*DIGITS-1:0] disp_s;

   function automatic logic [7:0] seg_glyph(input logic [3:0] v);
      case (v)
         4'd0: seg_glyph = 8'h3F;
         4'd1: seg_glyph = 8'h06;
         4'd2: seg_glyph = 8'h5B;
         4'd3: seg_glyph = 8'h4F;
         4'd4: seg_glyph = 8'h66;
         4'd5: seg_glyph = 8'h6D;
         4'd6: seg_glyph = 8'h7D;
         4'd7: seg_glyph = 8'h07;
         4'd8: seg_glyph = 8'h7F;
         4'd9: seg_glyph = 8'h6F;
         default: seg_glyph = 8'h00;
      endcase
   endfunction

   // Add 3 to every BCD digit that is 5 or more (one double-dabble correction)
   function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      r = v;
      for (int i = 0; i < ND; i++) begin
         if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
         else r[4*i +: 4] = v[4*i +: 4];
      end
      return r;
   endfunction

   function automatic logic [8*DIGITS-1:0] seg_pol(input logic [8*DIGITS-1:0] v);
      return SEG_ACTIVE_LOW ? ~v : v;
   endfunction

   assign cmd_ready = (state_r != ST_EXEC) && (state_r != ST_CONV);
   assign err       = (state_r == ST_ERR);
   assign busy      = busy_r;
   assign d         = d_r;

   // Command decode and operand-entry helpers (push a digit, drop a digit)
   always_comb begin
      accept_s    = cmd_valid & cmd_ready;
      is_digit_s  = (cmd <= 4'd9);
      is_oper_s   = (cmd >= 4'hA) && (cmd <= 4'hC);
      case (cmd)
         4'hA:    op_s = OP_ADD;
         4'hB:    op_s = OP_SUB;
         4'hC:    op_s = OP_MUL;
         default: op_s = OP_ADD;
      endcase
      ent_mag_s   = (state_r == ST_OPA) ? a_mag_r : b_mag_r;
      digit_mag_s = {{(WIDTH-4){1'b0}}, cmd};
      digit_bcd_s = {{(BW-4){1'b0}}, cmd};
      push_mag_s  = (ent_mag_s << 3) + (ent_mag_s << 1) + digit_mag_s;
      pop_mag_s   = ent_mag_s / WIDTH'(10);
      push_bcd_s  = {bcd_r[BW-5:0], cmd};
      pop_bcd_s   = {4'd0, bcd_r[BW-1:4]};
      can_push_s  = (cnt_r < CW'(ND));
      cnt_inc_s   = ((cnt_r == '0) && (cmd == 4'd0)) ? cnt_r : cnt_r + CW'(1);
      cnt_dec_s   = (cnt_r == '0) ? cnt_r : cnt_r - CW'(1);
      first_cnt_s = (cmd != 4'd0) ? CW'(1) : CW'(0);
      conv_bcd_s  = (dabble_adj(bcd_r) << 1) | {{(BW-1){1'b0}}, b_mag_r[WIDTH-1]};
   end

   // Sign-magnitude add/sub, multiplier step and result/overflow selection
   always_comb begin
      b_neg_s = (op_r == OP_SUB);
      if (a_neg_r == b_neg_s) begin
         as_sum_s = {1'b0, a_mag_r} + {1'b0, b_mag_r};
         as_neg_s = a_neg_r;
      end else if (a_mag_r >= b_mag_r) begin
         as_sum_s = {1'b0, a_mag_r} - {1'b0, b_mag_r};
         as_neg_s = a_neg_r;
      end else begin
         as_sum_s = {1'b0, b_mag_r} - {1'b0, a_mag_r};
         as_neg_s = b_neg_s;
      end
      as_ovf_s    = ({{(WIDTH-1){1'b0}}, as_sum_s} > MAX_VAL);
      prod_next_s = b_mag_r[0] ? prod_r + mcand_r : prod_r;
      mul_ovf_s   = (prod_next_s > MAX_VAL);
      mul_neg_s   = a_neg_r & (|prod_next_s);
      if (op_r == OP_MUL) begin
         res_mag_s = prod_next_s[WIDTH-1:0];
         res_neg_s = mul_neg_s;
         res_ovf_s = mul_ovf_s;
      end else begin
         res_mag_s = as_sum_s[WIDTH-1:0];
         res_neg_s = as_neg_s & (|as_sum_s);
         res_ovf_s = as_ovf_s;
      end
   end

   // Display image: right-aligned BCD with leading-zero blanking, sign or 'E'
   always_comb begin
      disp_s     = '0;
      seen_s     = 1'b0;
      disp_neg_s = a_neg_r & ((state_r == ST_OP) || (state_r == ST_RESULT));
      if (state_r == ST_ERR) begin
         disp_s[7:0] = 8'h79;
      end else begin
         for (int i = ND - 1; i >= 0; i--) begin
            if (seen_s || (bcd_r[4*i +: 4] != 4'd0) || (i == 0)) begin
               disp_s[8*i +: 8] = seg_glyph(bcd_r[4*i +: 4]);
               seen_s = 1'b1;
            end else begin
               disp_s[8*i +: 8] = 8'h00;
            end
         end
         disp_s[8*DIGITS-1 -: 8] = disp_neg_s ? 8'h40 : 8'h00;
      end
   end

   // Command state machine plus the sequential multiplier and BCD converter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_OPA;  op_r <= OP_ADD;  pend_op_r <= OP_ADD;
         chain_r <= 1'b0;    a_neg_r <= 1'b0; busy_r <= 1'b0;
         a_mag_r <= '0;      b_mag_r <= '0;   cnt_r <= '0;
         bcd_r <= '0;        step_r <= '0;    prod_r <= '0;  mcand_r <= '0;
      end else if (accept_s && (cmd == CMD_CLR)) begin
         state_r <= ST_OPA;  op_r <= OP_ADD;  pend_op_r <= OP_ADD;
         chain_r <= 1'b0;    a_neg_r <= 1'b0; busy_r <= 1'b0;
         a_mag_r <= '0;      b_mag_r <= '0;   cnt_r <= '0;
         bcd_r <= '0;        step_r <= '0;    prod_r <= '0;  mcand_r <= '0;
      end else begin
         case (state_r)
            ST_OPA: begin
               if (accept_s && is_digit_s && can_push_s) begin
                  a_mag_r <= push_mag_s; bcd_r <= push_bcd_s; cnt_r <= cnt_inc_s;
               end else if (accept_s && is_oper_s) begin
                  op_r <= op_s; state_r <= ST_OP;
               end else if (accept_s && (cmd == CMD_EQ)) begin
                  state_r <= ST_RESULT;
               end else if (accept_s && (cmd == CMD_BS)) begin
                  a_mag_r <= pop_mag_s; bcd_r <= pop_bcd_s; cnt_r <= cnt_dec_s;
               end
            end
            ST_OP: begin
               if (accept_s && is_oper_s) begin
                  op_r <= op_s;
               end else if (accept_s && is_digit_s) begin
                  b_mag_r <= digit_mag_s; bcd_r <= digit_bcd_s;
                  cnt_r <= first_cnt_s; state_r <= ST_OPB;
               end
            end
            ST_OPB: begin
               if (accept_s && is_digit_s && can_push_s) begin
                  b_mag_r <= push_mag_s; bcd_r <= push_bcd_s; cnt_r <= cnt_inc_s;
               end else if (accept_s && (cmd == CMD_BS)) begin
                  b_mag_r <= pop_mag_s; bcd_r <= pop_bcd_s; cnt_r <= cnt_dec_s;
               end else if (accept_s && ((cmd == CMD_EQ) || is_oper_s)) begin
                  state_r <= ST_EXEC; busy_r <= 1'b1; step_r <= '0; prod_r <= '0;
                  mcand_r <= {{WIDTH{1'b0}}, a_mag_r};
                  chain_r <= is_oper_s; pend_op_r <= op_s;
               end
            end
            ST_EXEC: begin
               if ((op_r == OP_MUL) && (step_r != LAST_STEP)) begin
                  prod_r <= prod_next_s; mcand_r <= mcand_r << 1;
                  b_mag_r <= b_mag_r >> 1; step_r <= step_r + SW'(1);
               end else if (res_ovf_s) begin
                  state_r <= ST_ERR; busy_r <= 1'b0; chain_r <= 1'b0;
               end else begin
                  a_mag_r <= res_mag_s; a_neg_r <= res_neg_s; b_mag_r <= res_mag_s;
                  bcd_r <= '0; step_r <= '0; state_r <= ST_CONV;
               end
            end
            ST_CONV: begin
               bcd_r <= conv_bcd_s; b_mag_r <= b_mag_r << 1; step_r <= step_r + SW'(1);
               if (step_r == LAST_STEP) begin
                  busy_r <= 1'b0; cnt_r <= '0;
                  if (chain_r) begin
                     state_r <= ST_OP; op_r <= pend_op_r; chain_r <= 1'b0;
                  end else begin
                     state_r <= ST_RESULT;
                  end
               end
            end
            ST_RESULT: begin
               if (accept_s && is_digit_s) begin
                  a_mag_r <= digit_mag_s; a_neg_r <= 1'b0; bcd_r <= digit_bcd_s;
                  cnt_r <= first_cnt_s; state_r <= ST_OPA;
               end else if (accept_s && is_oper_s) begin
                  op_r <= op_s; state_r <= ST_OP;
               end
            end
            ST_ERR: begin
               state_r <= ST_ERR;
            end
            default: begin
               state_r <= ST_OPA;
            end
         endcase
      end
   end

   // Segment register: follows the display image, frozen while computing
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         d_r <= seg_pol(RESET_IMG);
      end else if ((state_r == ST_EXEC) || (state_r == ST_CONV)) begin
         d_r <= d_r;
      end else begin
         d_r <= seg_pol(disp_s);
      end
   end
endmodule

// File: tb/tb_calc_core_param.sv
// Testbench for calc_core_param: directed scenarios followed by random keypad
// traffic. Expected values come from a decimal reference model.
module tb_calc_core_param;
   localparam int DIGITS = 8;
   localparam int WIDTH  = 24;
   localparam longint MAXV = 64'd9999999;
   localparam int BUSY_LIMIT = 3*WIDTH + 8;
   localparam int M_A = 0, M_OP = 1, M_B = 2, M_RES = 3, M_ERR = 4;

   logic        clock, reset, cmd_valid, cmd_ready, busy, err;
   logic [3:0]  cmd;
   logic [63:0] d;

   int errors = 0;
   int checks = 0;

   // reference model state (plain decimal arithmetic)
   int     m_mode, m_op, m_cnt, exp_busy;
   longint m_a, m_b, m_disp;

   logic [7:0] glyph [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

   calc_core_param #(.DIGITS(DIGITS), .WIDTH(WIDTH), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .busy(busy), .err(err), .d(d)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] render();
      logic [63:0] r;
      longint m, p;
      r = '0;
      if (m_mode == M_ERR) begin
         r[7:0] = 8'h79;
      end else begin
         m = (m_disp < 0) ? -m_disp : m_disp;
         p = 1;
         for (int i = 0; i < DIGITS - 1; i++) begin
            if (i == 0 || m >= p) r[8*i +: 8] = glyph[int'((m / p) % 10)];
            p = p * 10;
         end
         if (m_disp < 0) r[63:56] = 8'h40;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_mode = M_A; m_op = 0; m_cnt = 0; m_a = 0; m_b = 0; m_disp = 0;
   endtask

   task automatic model_exec(input bit chain, input int nop);
      longint r;
      if (m_op == 0) r = m_a + m_b;
      else if (m_op == 1) r = m_a - m_b;
      else r = m_a * m_b;
      if (r > MAXV || r < -MAXV) begin
         m_mode = M_ERR;
         exp_busy = (m_op == 2) ? WIDTH : 1;
      end else begin
         m_a = r; m_disp = r;
         exp_busy = (m_op == 2) ? 2*WIDTH : WIDTH + 1;
         if (chain) begin m_op = nop; m_mode = M_OP; end
         else m_mode = M_RES;
      end
   endtask

   task automatic model_step(input logic [3:0] c);
      int  dg;
      bit  is_dig, is_op;
      dg = int'(c);
      is_dig = (dg <= 9);
      is_op  = (dg >= 10 && dg <= 12);
      exp_busy = 0;
      if (dg == 13) begin
         model_reset();
      end else begin
         case (m_mode)
            M_A: begin
               if (is_dig) begin
                  if (m_cnt < DIGITS - 1) begin
                     m_a = m_a * 10 + dg;
                     if (!(m_cnt == 0 && dg == 0)) m_cnt++;
                     m_disp = m_a;
                  end
               end else if (is_op) begin m_op = dg - 10; m_mode = M_OP; end
               else if (dg == 14) m_mode = M_RES;
               else begin m_a = m_a / 10; if (m_cnt > 0) m_cnt--; m_disp = m_a; end
            end
            M_OP: begin
               if (is_op) m_op = dg - 10;
               else if (is_dig) begin
                  m_b = dg; m_cnt = (dg != 0) ? 1 : 0; m_disp = dg; m_mode = M_B;
               end
            end
            M_B: begin
               if (is_dig) begin
                  if (m_cnt < DIGITS - 1) begin
                     m_b = m_b * 10 + dg;
                     if (!(m_cnt == 0 && dg == 0)) m_cnt++;
                     m_disp = m_b;
                  end
               end else if (dg == 15) begin
                  m_b = m_b / 10; if (m_cnt > 0) m_cnt--; m_disp = m_b;
               end else if (dg == 14) model_exec(1'b0, 0);
               else model_exec(1'b1, dg - 10);
            end
            M_RES: begin
               if (is_dig) begin
                  m_a = dg; m_cnt = (dg != 0) ? 1 : 0; m_disp = dg; m_mode = M_A;
               end else if (is_op) begin m_op = dg - 10; m_mode = M_OP; end
            end
            default: ;
         endcase
      end
   endtask

   // Count busy cycles from the current negedge, poking random commands meanwhile
   task automatic wait_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < BUSY_LIMIT) begin
         n++;
         cmd_valid = 1'($urandom_range(0, 1));
         cmd = 4'($urandom_range(0, 15));
         @(negedge clock);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic send(input logic [3:0] c);
      int n;
      @(negedge clock);
      cmd = c; cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
      cmd = 4'($urandom_range(0, 15));
      model_step(c);
      wait_busy(n);
      check($sformatf("busy_len cmd=%h", c), 64'(n), 64'(exp_busy));
      @(negedge clock);
      check($sformatf("display cmd=%h", c), d, render());
      check($sformatf("err cmd=%h", c), 64'(err), 64'(m_mode == M_ERR));
      check($sformatf("ready cmd=%h", c), 64'(cmd_ready), 64'(1));
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, r;
      logic [3:0] c;
      reset = 1'b0; cmd = 4'd0; cmd_valid = 1'b0;
      model_reset();
      #12;
      check("reset_d", d, 64'h3F);
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_err", 64'(err), 64'(0));
      check("reset_ready", 64'(cmd_ready), 64'(1));
      @(negedge clock); reset = 1'b1;

      // 3+1
      send(4'd3); send(4'hA); send(4'd1); send(4'hE);
      // 1-5, then times 2 on the negative result
      send(4'hD); send(4'd1); send(4'hB); send(4'd5); send(4'hE);
      send(4'hC); send(4'd2); send(4'hE);
      // 3+8, then a new 2*3
      send(4'hD); send(4'd3); send(4'hA); send(4'd8); send(4'hE);
      send(4'd2); send(4'hC); send(4'd3); send(4'hE);
      // chaining 2+3+ then 4=
      send(4'hD); send(4'd2); send(4'hA); send(4'd3); send(4'hA);
      send(4'd4); send(4'hE);
      // overflow into ERR, ignored commands, clear
      send(4'hD);
      repeat (7) send(4'd9);
      send(4'hC); send(4'd9); send(4'hE);
      send(4'd5); send(4'hE); send(4'hD);
      // eight digits with leading zero, backspace
      send(4'd0);
      for (int i = 1; i <= 8; i++) send(4'(i));
      send(4'hF); send(4'hF);
      // add overflow and big subtraction
      send(4'hA);
      repeat (7) send(4'd9);
      send(4'hB);
      repeat (7) send(4'd9);
      send(4'hE);
      send(4'hD); send(4'd7); send(4'hB);
      repeat (3) send(4'd9);
      send(4'hE);

      // equals held high across the busy window must execute once
      send(4'hD); send(4'd3); send(4'hA); send(4'd4);
      @(negedge clock); cmd = 4'hE; cmd_valid = 1'b1;
      @(negedge clock);
      model_step(4'hE);
      n = 0;
      while (busy === 1'b1 && n < BUSY_LIMIT) begin n++; @(negedge clock); end
      check("held_eq_busy_len", 64'(n), 64'(exp_busy));
      @(negedge clock);
      @(negedge clock); cmd_valid = 1'b0;
      check("held_eq_no_rerun", 64'(busy), 64'(0));
      check("held_eq_display", d, render());

      // reset asserted in the middle of a multiply
      send(4'hD); send(4'd5); send(4'hC); send(4'd7);
      @(negedge clock); cmd = 4'hE; cmd_valid = 1'b1;
      @(negedge clock); cmd_valid = 1'b0;
      repeat (10) @(negedge clock);
      check("mid_mul_busy", 64'(busy), 64'(1));
      #2 reset = 1'b0;
      #1;
      check("mid_mul_reset_d", d, 64'h3F);
      check("mid_mul_reset_busy", 64'(busy), 64'(0));
      check("mid_mul_reset_err", 64'(err), 64'(0));
      check("mid_mul_reset_ready", 64'(cmd_ready), 64'(1));
      @(negedge clock); reset = 1'b1;
      model_reset();

      // random keypad traffic against the model
      repeat (250) begin
         r = int'($urandom_range(0, 99));
         if (m_mode == M_ERR && r < 40) c = 4'hD;
         else if (r < 50) c = 4'($urandom_range(0, 9));
         else if (r < 68) c = 4'($urandom_range(10, 12));
         else if (r < 80) c = 4'hE;
         else if (r < 92) c = 4'hF;
         else if (r < 95) c = 4'hD;
         else c = 4'($urandom_range(0, 15));
         send(c);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
